gcd_feeder: RTL and testbench

GCD_FEEDER -- requirements
Module: gcd_feeder

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_pair_fifo.sv | 66 ++++++
 rtl/gcd_feeder.sv | 144 ++++++++++++++
 tb/tb_gcd_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD feeder: default operand width,
// default WAIT timeout and the feeder FSM state encoding.
package gcd_pkg;

    localparam int unsigned GCD_W       = 16;
    localparam int unsigned GCD_TIMEOUT = 65600;

    typedef enum logic [2:0] {
        ST_CLR    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_WAIT   = 3'd4,
        ST_OUT    = 3'd5
    } state_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Two-entry FIFO of operand pairs.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   push, din      write request and pair payload (ignored while full)
//   pop            read request (ignored while empty)
//   head_c         current head entry (combinational read of storage)
//   full, empty    registered status flags
module gcd_pair_fifo #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head_c,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [1:0]    count_nxt;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO never takes a push, even when a pop happens in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head_c  = mem[rd_ptr];

    // Occupancy update.
    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - 2'd1;
        end
    end

    // Pointers and flags; full reads high during reset so no push is taken then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            full   <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count_nxt;
            full  <= (count_nxt == 2'd2);
            empty <= (count_nxt == 2'd0);
        end
    end

    // Payload storage.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gcd_feeder.sv
// Feeds buffered operand pairs to an external GCD datapath/controller pair,
// bypasses the core when an operand is zero, and returns results in order
// with a timeout flag.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready, in_a/b  operand-pair handshake
//   core_start/data/clr        core control: start strobe, data_in bus, clear
//   core_done, core_result     core status and A-register value
//   out_valid/out_ready        result handshake
//   out_gcd, out_err           result and timeout flag
module gcd_feeder
    import gcd_pkg::*;
#(
    parameter int unsigned W       = GCD_W,
    parameter int unsigned TIMEOUT = GCD_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         core_start,
    output logic [W-1:0] core_data,
    output logic         core_clr,
    input  logic         core_done,
    input  logic [W-1:0] core_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic         out_err
);

    localparam int unsigned CW = W + 1;
    localparam int unsigned PW = 2 * W;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  gcd_d;
    logic          err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;
    logic          push;
    logic          full;
    logic          empty;
    logic [PW-1:0] head;
    logic [W-1:0]  head_a;
    logic [W-1:0]  head_b;

    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign head_a   = head[PW-1:W];
    assign head_b   = head[W-1:0];

    gcd_pair_fifo #(.DW(PW)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .din    ({in_a, in_b}),
        .pop    (pop),
        .head_c (head),
        .full   (full),
        .empty  (empty)
    );

    // Next state, operand capture, timeout counter and result selection.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gcd_d   = out_gcd;
        err_d   = out_err;
        unique case (state_q)
            ST_CLR: state_d = ST_IDLE;
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    a_d = head_a;
                    b_d = head_b;
                    if ((head_a != '0) && (head_b != '0)) begin
                        state_d = ST_LOAD_A;
                    end else begin
                        // gcd(x,0) = x, and 0 when both are zero.
                        gcd_d   = head_a | head_b;
                        err_d   = 1'b0;
                        state_d = ST_OUT;
                    end
                end
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (core_done) begin
                    gcd_d   = core_result;
                    err_d   = 1'b0;
                    state_d = ST_OUT;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This edge brings the counter to TIMEOUT: abort.
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) state_d = ST_CLR;
            end
            default: state_d = ST_CLR;
        endcase
    end

    // State and registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLR;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            out_gcd    <= '0;
            out_err    <= 1'b0;
            out_valid  <= 1'b0;
            core_start <= 1'b0;
            core_data  <= '0;
            core_clr   <= 1'b1;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            out_gcd    <= gcd_d;
            out_err    <= err_d;
            out_valid  <= (state_d == ST_OUT);
            core_start <= (state_d == ST_LOAD_A);
            core_clr   <= (state_d == ST_CLR);
            core_data  <= (state_d == ST_LOAD_B) ? b_d : a_d;
        end
    end

endmodule

// File: tb/tb_gcd_feeder.sv
// Directed bench for gcd_feeder with a behavioural subtract-and-swap GCD core.
module tb_gcd_feeder;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         core_start;
    logic [W-1:0] core_data;
    logic         core_clr;
    logic         core_done;
    logic [W-1:0] core_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gcd;
    logic         out_err;

    int n_tests = 0;
    int n_fail  = 0;
    int starts  = 0;

    always #5 clk = ~clk;

    gcd_feeder #(.W(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_clr    (core_clr),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_gcd     (out_gcd),
        .out_err     (out_err)
    );

    // Behavioural core: load A on start, B next cycle, then subtract/swap until B==0.
    int           phase = 0;
    logic [W-1:0] ca = '0;
    logic [W-1:0] cb = '0;
    logic         cdone = 1'b0;
    bit           stuck = 1'b0;

    assign core_result = ca;
    assign core_done   = cdone & ~stuck;

    always @(posedge clk) begin
        if (core_clr) begin
            phase <= 0;
            cdone <= 1'b0;
        end else begin
            case (phase)
                0: if (core_start) begin ca <= core_data; phase <= 1; end
                1: begin cb <= core_data; phase <= 2; end
                2: begin
                    if (cb == '0) begin
                        cdone <= 1'b1;
                        phase <= 3;
                    end else if (ca < cb) begin
                        ca <= cb;
                        cb <= ca;
                    end else begin
                        ca <= ca - cb;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) if (core_start === 1'b1) starts++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (core_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic collect(input string tag, input logic [W-1:0] eg, input logic ee);
        wait_valid();
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " gcd"}, 32'(out_gcd), 32'(eg));
        check({tag, " err"}, 32'(out_err), 32'(ee));
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        int seen;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_gcd", 32'(out_gcd), 32'd0);
        check("rst out_err", 32'(out_err), 32'd0);
        check("rst core_start", 32'(core_start), 32'd0);
        check("rst core_data", 32'(core_data), 32'd0);
        check("rst core_clr", 32'(core_clr), 32'd1);
        rst_n = 1'b1;
        #1;
        check("rel core_clr", 32'(core_clr), 32'd1);
        @(negedge clk);
        check("rel1 core_clr", 32'(core_clr), 32'd0);
        check("rel1 in_ready", 32'(in_ready), 32'd1);

        // (48,18) through the core.
        s0 = starts;
        out_ready = 1'b1;
        push(16'd48, 16'd18);
        wait_start();
        check("t1 start", 32'(core_start), 32'd1);
        check("t1 data a", 32'(core_data), 32'd48);
        @(negedge clk);
        check("t1 start low", 32'(core_start), 32'd0);
        check("t1 data b", 32'(core_data), 32'd18);
        collect("t1", 16'd6, 1'b0);
        check("t1 start count", 32'(starts - s0), 32'd1);

        // Zero bypass: (0,7) then (0,0).
        repeat (3) @(negedge clk);
        s0 = starts;
        push(16'd0, 16'd7);
        check("t2 lat0 valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t2 lat1 valid", 32'(out_valid), 32'd1);
        check("t2 gcd", 32'(out_gcd), 32'd7);
        check("t2 err", 32'(out_err), 32'd0);
        push(16'd0, 16'd0);
        collect("t2b", 16'd0, 1'b0);
        check("t2 start count", 32'(starts - s0), 32'd0);

        // Back-pressure: three pairs with out_ready low, then drain in order.
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        push(16'd48, 16'd18);
        push(16'd35, 16'd25);
        push(16'd17, 16'd4);
        check("t3 full", 32'(in_ready), 32'd0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3 hold valid", 32'(out_valid), 32'd1);
            check("t3 hold gcd", 32'(out_gcd), 32'd6);
            check("t3 hold err", 32'(out_err), 32'd0);
            check("t3 hold no pop", 32'(in_ready), 32'd0);
        end
        collect("t3a", 16'd6, 1'b0);
        collect("t3b", 16'd5, 1'b0);
        collect("t3c", 16'd1, 1'b0);

        // Timeout: core never signals done.
        repeat (3) @(negedge clk);
        stuck = 1'b1;
        out_ready = 1'b0;
        push(16'd9, 16'd3);
        wait_start();
        check("t4 start", 32'(core_start), 32'd1);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4 cycles", 32'(n), 32'd22);
        check("t4 err", 32'(out_err), 32'd1);
        check("t4 gcd", 32'(out_gcd), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4 clr after accept", 32'(core_clr), 32'd1);
        check("t4 valid drop", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t4 clr one cycle", 32'(core_clr), 32'd0);
        stuck = 1'b0;

        // Reset mid-WAIT with one pair still buffered.
        repeat (3) @(negedge clk);
        push(16'd100, 16'd75);
        push(16'd21, 16'd14);
        wait_start();
        repeat (4) @(negedge clk);
        check("t5 pre valid", 32'(out_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 rst valid", 32'(out_valid), 32'd0);
        check("t5 rst gcd", 32'(out_gcd), 32'd0);
        check("t5 rst err", 32'(out_err), 32'd0);
        check("t5 rst start", 32'(core_start), 32'd0);
        check("t5 rst data", 32'(core_data), 32'd0);
        check("t5 rst clr", 32'(core_clr), 32'd1);
        check("t5 rst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("t5 no stale result", 32'(seen), 32'd0);
        push(16'd12, 16'd8);
        collect("t5", 16'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
